// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared FSM encoding, port indices and default widths for the data-memory arbiter
package dmem_arbiter_pkg;
   localparam int DEF_AW = 8;
   localparam int DEF_DW = 8;
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/grant/done handshake bundle for both arbiter ports
interface dmem_arbiter_if
   import dmem_arbiter_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
);
   logic req0, req1, we0, we1;
   logic gnt0, gnt1, done0, done1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1, rdata;
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, done0, done1, rdata
   );
   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, done0, done1, rdata
   );
endinterface

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: two-way selector; a lone request wins, a tie goes to the port named by ptr
module dmem_arb_pick (
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   output logic win,
   output logic valid
);
   // port 1 wins when it is alone or when the tie pointer favours it
   always_comb begin
      valid = req0 | req1;
      win   = req1 & (~req0 | ptr);
   end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises two load/store ports onto one data memory; DMEM_ARB_RR_EN selects round-robin ties
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_ADDRESS_WIDTH = DEF_AW,
   parameter int DATA_WIDTH         = DEF_DW
)(
   input  logic                          clk,
   input  logic                          reset_n,
   dmem_arbiter_if.slave                 bus,
   output logic [DATA_ADDRESS_WIDTH-1:0] address_in_bus,
   output logic [DATA_WIDTH-1:0]         data_in_bus,
   input  logic [DATA_WIDTH-1:0]         data_out_bus,
   output logic                          MW
);
   arb_state_e state_q, state_d;
   logic port_q, port_d, we_q, we_d, mw_q, mw_d;
   logic [DATA_ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [1:0] done_q, done_d;
   logic ptr, win, valid;
`ifdef DMEM_ARB_RR_EN
   logic ptr_q, ptr_d;
   assign ptr = ptr_q;
`else
   assign ptr = PORT_CPU;
`endif

   dmem_arb_pick u_pick (
      .req0  (bus.req0),
      .req1  (bus.req1),
      .ptr   (ptr),
      .win   (win),
      .valid (valid)
   );

   // grant is offered only while idle and out of reset so the latch edge and the pulse coincide
   assign bus.gnt0 = reset_n && state_q == IDLE && valid && win == PORT_CPU;
   assign bus.gnt1 = reset_n && state_q == IDLE && valid && win == PORT_DBG;
   assign bus.done0 = done_q[0];
   assign bus.done1 = done_q[1];
   assign bus.rdata = rdata_q;
   assign address_in_bus = addr_q;
   assign data_in_bus = wdata_q;
   assign MW = mw_q;

   // next-state: latch the winner in IDLE, strobe MW/capture data in ACCESS, retire in RESP
   always_comb begin
      state_d = state_q;
      port_d  = port_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      mw_d    = 1'b0;
      done_d  = 2'b00;
`ifdef DMEM_ARB_RR_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         IDLE: if (valid) begin
            state_d = ACCESS;
            port_d  = win;
            we_d    = win ? bus.we1 : bus.we0;
            addr_d  = win ? bus.addr1 : bus.addr0;
            wdata_d = win ? bus.wdata1 : bus.wdata0;
            mw_d    = we_d;
         end
         ACCESS: begin
            state_d = RESP;
            rdata_d = we_q ? rdata_q : data_out_bus;
            done_d[port_q] = 1'b1;
         end
         RESP: begin
            state_d = IDLE;
`ifdef DMEM_ARB_RR_EN
            ptr_d = ~port_q;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // all state and memory-facing outputs registered; reset also aborts an in-flight access
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         port_q  <= PORT_CPU;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         mw_q    <= 1'b0;
         done_q  <= 2'b00;
`ifdef DMEM_ARB_RR_EN
         ptr_q   <= PORT_CPU;
`endif
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         mw_q    <= mw_d;
         done_q  <= done_d;
`ifdef DMEM_ARB_RR_EN
         ptr_q   <= ptr_d;
`endif
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors for the two-port data-memory arbiter
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [7:0] address_in_bus, data_in_bus, data_out_bus;
   logic MW;
   logic [7:0] mem [256];
   int n_vec = 0, n_bad = 0;
   int c0, c1, ng, last, cyc;
`ifdef DMEM_ARB_RR_EN
   localparam logic [7:0] EXP_ORD = 8'b10101010;
`else
   localparam logic [7:0] EXP_ORD = 8'b11110000;
`endif

   always #5 clk = ~clk;

   dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

   dmem_arbiter #(.DATA_ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .bus            (bus.slave),
      .address_in_bus (address_in_bus),
      .data_in_bus    (data_in_bus),
      .data_out_bus   (data_out_bus),
      .MW             (MW)
   );

   always @(posedge clk) if (MW) mem[address_in_bus] <= data_in_bus;
   assign data_out_bus = mem[address_in_bus];

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_req(input logic p, input logic we, input logic [7:0] a, input logic [7:0] d, input logic [7:0] rd);
      logic g;
      g = 1'b0;
      if (p) begin
         bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
      end else begin
         bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
      end
      for (int i = 0; i < 10; i++) begin
         #1;
         g = p ? bus.gnt1 : bus.gnt0;
         if (g) break;
         @(posedge clk);
      end
      chk("gnt", 16'(g), 16'd1);
      if (!g) begin
         bus.req0 = 1'b0;
         bus.req1 = 1'b0;
         return;
      end
      chk("gnt_other", 16'(p ? bus.gnt0 : bus.gnt1), 16'd0);
      @(posedge clk); #1;
      if (p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
      chk("mw_access", 16'(MW), 16'(we));
      chk("addr_access", 16'(address_in_bus), 16'(a));
      if (we) chk("wdata_access", 16'(data_in_bus), 16'(d));
      chk("done_early", 16'({bus.done1, bus.done0}), 16'd0);
      @(posedge clk); #1;
      chk("mw_resp", 16'(MW), 16'd0);
      chk("addr_resp", 16'(address_in_bus), 16'(a));
      chk("done", 16'({bus.done1, bus.done0}), p ? 16'd2 : 16'd1);
      chk("rdata", 16'(bus.rdata), 16'(rd));
      @(posedge clk); #1;
      chk("done_clr", 16'({bus.done1, bus.done0}), 16'd0);
   endtask

   initial begin
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
      bus.addr0 = 8'h00; bus.addr1 = 8'h00; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
      // reset held with a pending request: nothing may be granted
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h00; bus.wdata0 = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_gnt0", 16'(bus.gnt0), 16'd0);
         chk("rst_mw", 16'(MW), 16'd0);
      end
      chk("rst_addr", 16'(address_in_bus), 16'd0);
      chk("rst_wdata", 16'(data_in_bus), 16'd0);
      chk("rst_rdata", 16'(bus.rdata), 16'd0);
      chk("rst_done", 16'({bus.done1, bus.done0}), 16'd0);
      reset_n = 1'b1;
      do_req(1'b0, 1'b1, 8'h00, 8'h5A, 8'h00);
      // port 0 store then load, port 1 store then port 0 load
      do_req(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00);
      do_req(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
      do_req(1'b1, 1'b1, 8'hFF, 8'h3C, 8'hA5);
      do_req(1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C);
      // reset lands during the ACCESS cycle of a store
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h20; bus.wdata0 = 8'h77;
      #1;
      chk("gnt_pre_rst", 16'(bus.gnt0), 16'd1);
      @(posedge clk); #1;
      bus.req0 = 1'b0;
      chk("mw_pre_rst", 16'(MW), 16'd1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("mw_after_rst", 16'(MW), 16'd0);
      chk("done_after_rst", 16'({bus.done1, bus.done0}), 16'd0);
      chk("rdata_after_rst", 16'(bus.rdata), 16'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("done_after_rst2", 16'({bus.done1, bus.done0}), 16'd0);
      do_req(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5);
      // both ports loading continuously, four grants each
      c0 = 0; c1 = 0; ng = 0; last = 0; cyc = 0;
      bus.we0 = 1'b0; bus.we1 = 1'b0; bus.addr0 = 8'h10; bus.addr1 = 8'hFF;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      for (int i = 0; i < 60 && ng < 8; i++) begin
         #1;
         chk("gnt_both", 16'(bus.gnt0 & bus.gnt1), 16'd0);
         if (bus.gnt0 | bus.gnt1) begin
            chk($sformatf("order%0d", ng), 16'(bus.gnt1), 16'(EXP_ORD[ng]));
            if (ng > 0) chk("spacing", 16'(cyc - last), 16'd3);
            last = cyc;
            ng++;
            if (bus.gnt0) c0++; else c1++;
         end
         @(posedge clk); #1;
         cyc++;
         bus.req0 = c0 < 4;
         bus.req1 = c1 < 4;
      end
      chk("grants", 16'(ng), 16'd8);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
